// File: rtl/mcu_pkg.sv
// mcu_pkg: shared opcodes, FSM state type and width
// defaults for the mcu_sequencer slice.
package mcu_pkg;

  localparam int MCU_DATA_W = 8;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_OUT  = 4'h4;
  localparam logic [3:0] OP_CLR  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_e;

  // ALU opcodes occupy 0x0..0x3 and need an external operand
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

endpackage

// File: rtl/mcu_alu.sv
// mcu_alu: combinational 2-bit-op ALU, wraps modulo 2^DATA_W.
// op 0=ADD 1=SUB 2=AND 3=OR.
module mcu_alu
  import mcu_pkg::*;
#(
  parameter int DATA_W = MCU_DATA_W
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  // Select the result; no flags are produced
  always_comb begin
    y_o = a_i + b_i;
    unique case (op_i)
      2'd0: y_o = a_i + b_i;
      2'd1: y_o = a_i - b_i;
      2'd2: y_o = a_i & b_i;
      2'd3: y_o = a_i | b_i;
      default: y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multi-cycle FETCH/OPERAND/EXEC program
// sequencer with program memory and 16x8 register file.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int DATA_W     = MCU_DATA_W,
  parameter int PROG_DEPTH = 16,
  parameter int NREGS      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(PROG_DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          start,
  input  logic                          operand_valid,
  input  logic [DATA_W-1:0]             operand,
  output logic                          operand_ready,
  output logic [DATA_W-1:0]             data_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          halted,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int PC_W = $clog2(PROG_DEPTH);

  state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovld_q, ovld_d;
  logic [DATA_W-1:0] fetch_w, rd_val;
  logic [DATA_W-1:0] alu_y, wr_val;
  logic              wr_en, load_ok;
  logic [3:0]        opc, rd, f_opc;

  logic [DATA_W-1:0] prog_q [PROG_DEPTH];
  logic [DATA_W-1:0] regs_q [NREGS];

  assign fetch_w = prog_q[pc_q];
  assign f_opc   = fetch_w[7:4];
  assign opc     = ir_q[7:4];
  assign rd      = ir_q[3:0];
  assign rd_val  = regs_q[rd];

  assign pc_inc = (pc_q == PC_W'(PROG_DEPTH - 1))
                ? '0 : pc_q + PC_W'(1);

  assign load_ok = load_en &&
                   (state_q == S_IDLE || state_q == S_HALT);

  mcu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i (opc[1:0]),
    .a_i  (rd_val),
    .b_i  (operand),
    .y_o  (alu_y)
  );

  // Next-state, PC, IR, result and register write control
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    dout_d  = dout_q;
    ovld_d  = 1'b0;
    wr_en   = 1'b0;
    wr_val  = '0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d = fetch_w;
        if (is_alu_op(f_opc))
          state_d = S_OPERAND;
        else if (f_opc == OP_HALT)
          state_d = S_HALT;
        else
          state_d = S_EXEC;
      end
      S_OPERAND: begin
        if (operand_valid) begin
          wr_en   = 1'b1;
          wr_val  = alu_y;
          dout_d  = alu_y;
          ovld_d  = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        if (opc == OP_OUT) begin
          dout_d = rd_val;
          ovld_d = 1'b1;
        end else if (opc == OP_CLR) begin
          wr_en  = 1'b1;
          wr_val = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, PC, IR and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      dout_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      dout_q  <= dout_d;
      ovld_q  <= ovld_d;
    end
  end

  // Register file, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= wr_val;
    end
  end

  // Program memory survives reset; writes only while not running
  always_ff @(posedge clk) begin
    if (load_ok)
      prog_q[load_addr] <= load_data;
  end

  assign operand_ready = (state_q == S_OPERAND);
  assign busy          = (state_q == S_FETCH) ||
                         (state_q == S_OPERAND) ||
                         (state_q == S_EXEC);
  assign halted        = (state_q == S_HALT);
  assign pc            = pc_q;
  assign data_out      = dout_q;
  assign out_valid     = ovld_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: directed program runs checked against an
// instruction-level model of the sequencer.
module tb_mcu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_en, start, operand_valid;
  logic [3:0] load_addr;
  logic [7:0] load_data, operand;
  logic       operand_ready, out_valid, busy, halted;
  logic [7:0] data_out;
  logic [3:0] pc;

  int errors = 0;
  int checks = 0;

  logic [7:0] bmem  [16];
  logic [7:0] bregs [16];
  logic [7:0] expq [$];
  logic [7:0] obs  [$];
  logic [7:0] opq  [$];
  int         exp_pc;
  logic       exp_halt;

  always #5 clk = ~clk;

  mcu_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .operand_valid (operand_valid),
    .operand       (operand),
    .operand_ready (operand_ready),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .halted        (halted),
    .pc            (pc)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // every out_valid pulse must match the next modelled result
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      obs.push_back(data_out);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: data_out=%0h none required",
                 data_out);
      end else begin
        chk("data_out", {24'h0, data_out}, {24'h0, expq.pop_front()});
      end
    end
  end

  // instruction-level model: walks the program, fills expq
  function automatic void model(input logic [7:0] ops [$],
                                input int max_steps);
    int p;
    int n;
    logic [7:0] ins, b;
    logic [3:0] o, r;
    p = 0;
    n = 0;
    exp_halt = 1'b0;
    while (n < max_steps) begin
      ins = bmem[p];
      o = ins[7:4];
      r = ins[3:0];
      n++;
      if (o == 4'hF) begin
        exp_halt = 1'b1;
        break;
      end
      if (o <= 4'h3) begin
        b = ops.pop_front();
        case (o)
          4'h0: bregs[r] = bregs[r] + b;
          4'h1: bregs[r] = bregs[r] - b;
          4'h2: bregs[r] = bregs[r] & b;
          default: bregs[r] = bregs[r] | b;
        endcase
        expq.push_back(bregs[r]);
      end else if (o == 4'h4) begin
        expq.push_back(bregs[r]);
      end else if (o == 4'h5) begin
        bregs[r] = 8'h00;
      end
      p = (p + 1) % 16;
    end
    exp_pc = p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    load_en = 1'b0;
    #1;
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_ready", {31'h0, operand_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_pc", {28'h0, pc}, 32'h0);
    operand_valid = 1'b0;
    for (int i = 0; i < 16; i++) bregs[i] = 8'h00;
    expq.delete();
    obs.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    bmem[a] = d;
  endtask

  task automatic load_prog(input logic [7:0] w [$]);
    foreach (w[i]) load(4'(i), w[i]);
  endtask

  task automatic run(input logic [7:0] ops [$], input int hold,
                     input int wait_pc, input bit wl,
                     input logic [3:0] la, input logic [7:0] ld);
    int  cyc;
    int  w;
    bit  pop_now;
    cyc = 0;
    w = 0;
    if (wl) bmem[la] = ld;
    model(ops, 64);
    opq = ops;
    @(negedge clk);
    start = 1'b1;
    load_en = wl;
    load_addr = la;
    load_data = ld;
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
    while (halted !== 1'b1 && cyc < 200) begin
      operand_valid = operand_ready && opq.size() > 0 && w >= hold;
      operand = operand_valid ? opq[0] : 8'h00;
      pop_now = operand_valid;
      if (hold > 0 && operand_ready && !operand_valid) begin
        chk("wait_ready_pc", {28'h0, pc}, 32'(wait_pc));
        chk("wait_no_out", {31'h0, out_valid}, 32'h0);
      end
      if (operand_ready) w++;
      @(negedge clk);
      cyc++;
      if (pop_now) begin
        chk("out_next_cycle", {31'h0, out_valid}, 32'h1);
        void'(opq.pop_front());
        w = 0;
      end
    end
    operand_valid = 1'b0;
    chk("halted", {31'h0, halted}, {31'h0, exp_halt});
    chk("final_pc", {28'h0, pc}, 32'(exp_pc));
    chk("exp_drained", 32'(expq.size()), 32'h0);
    chk("ops_consumed", 32'(opq.size()), 32'h0);
  endtask

  task automatic chk_obs(input string nm, input logic [7:0] req [$]);
    chk({nm, "_count"}, 32'(obs.size()), 32'(req.size()));
    foreach (req[i])
      if (i < obs.size())
        chk(nm, {24'h0, obs[i]}, {24'h0, req[i]});
    obs.delete();
  endtask

  initial begin
    int k;
    reset = 1'b1;
    load_en = 1'b0;
    start = 1'b0;
    operand_valid = 1'b0;
    load_addr = 4'h0;
    load_data = 8'h00;
    operand = 8'h00;
    for (int i = 0; i < 16; i++) bmem[i] = 8'h00;
    do_reset();

    // ADD, SUB, OUT on r3 then HALT
    load_prog('{8'h03, 8'h13, 8'h43, 8'hF0});
    run('{8'h0A, 8'h03}, 0, 0, 1'b0, 4'h0, 8'h00);
    chk_obs("t1_out", '{8'h0A, 8'h07, 8'h07});
    chk("t1_pc", {28'h0, pc}, 32'h3);

    // load+start together: new word at 0 is what gets fetched
    run('{8'h02}, 0, 0, 1'b1, 4'h0, 8'h43);
    chk_obs("t1b_out", '{8'h07, 8'h05, 8'h05});

    // ADD, AND, OR on r1
    do_reset();
    load_prog('{8'h01, 8'h21, 8'h31, 8'hF0});
    run('{8'hF0, 8'h3C, 8'h05}, 0, 0, 1'b0, 4'h0, 8'h00);
    chk_obs("t2_out", '{8'hF0, 8'h30, 8'h35});

    // SUB underflow wraps
    do_reset();
    load_prog('{8'h10, 8'hF0});
    run('{8'h01}, 0, 0, 1'b0, 4'h0, 8'h00);
    chk_obs("t3_out", '{8'hFF});

    // operand withheld five cycles in OPERAND
    do_reset();
    load_prog('{8'h02, 8'hF0});
    run('{8'h11}, 5, 0, 1'b0, 4'h0, 8'h00);
    chk_obs("t4_out", '{8'h11});

    // all-NOP program: pc walks and wraps; busy-time start/load ignored
    do_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 8'h60);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand_valid = 1'b1;
    operand = 8'h77;
    for (k = 0; k < 40; k++) begin
      chk("nop_pc", {28'h0, pc}, 32'((k / 2) % 16));
      chk("nop_busy", {31'h0, busy}, 32'h1);
      chk("nop_halted", {31'h0, halted}, 32'h0);
      start = (k == 7);
      load_en = (k == 9);
      load_addr = 4'h5;
      load_data = 8'hF0;
      @(negedge clk);
    end
    start = 1'b0;
    load_en = 1'b0;
    operand_valid = 1'b0;
    do_reset();
    load(4'hF, 8'hF0);
    run('{}, 0, 0, 1'b0, 4'h0, 8'h00);
    chk("nop_halt_pc", {28'h0, pc}, 32'hF);
    obs.delete();

    // reset mid-OPERAND with a pending operand, then rerun
    do_reset();
    load_prog('{8'h03, 8'h13, 8'h43, 8'hF0});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (operand_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_operand", {31'h0, operand_ready}, 32'h1);
    operand_valid = 1'b1;
    operand = 8'h55;
    #2;
    do_reset();
    run('{8'h0A, 8'h03}, 0, 0, 1'b0, 4'h0, 8'h00);
    chk_obs("t6_out", '{8'h0A, 8'h07, 8'h07});
    chk("t6_pc", {28'h0, pc}, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
